// File: rtl/noaa_sample_feeder_if.sv
// noaa_sample_feeder_if
//   Groups the sensor handshake, engine, and host/result signals of the
//   NOAA sample feeder into one bundle.
//   master : the sensor/engine/host side that drives the feeder's inputs
//   slave  : the feeder itself
//   Sensor : SENS_VALID, SENS_DATA (12b) -> feeder ; SENS_READY <- feeder
//   Engine : SAMPLE, DONE, AVG_SD (12b) -> feeder ; TN (12b), MODE <- feeder
//   Host   : MODE_SEL -> feeder ; RESULT (12b), RESULT_MODE, RESULT_VALID,
//            UNDERRUN, OVERFLOW, UNDERRUN_CNT (8b) <- feeder
interface noaa_sample_feeder_if;
    logic        SENS_VALID;
    logic [11:0] SENS_DATA;
    logic        SENS_READY;
    logic        SAMPLE;
    logic [11:0] TN;
    logic        MODE;
    logic        DONE;
    logic [11:0] AVG_SD;
    logic        MODE_SEL;
    logic [11:0] RESULT;
    logic        RESULT_MODE;
    logic        RESULT_VALID;
    logic        UNDERRUN;
    logic        OVERFLOW;
    logic [7:0]  UNDERRUN_CNT;

    modport master (
        output SENS_VALID, SENS_DATA, SAMPLE, DONE, AVG_SD, MODE_SEL,
        input  SENS_READY, TN, MODE, RESULT, RESULT_MODE, RESULT_VALID,
               UNDERRUN, OVERFLOW, UNDERRUN_CNT
    );

    modport slave (
        input  SENS_VALID, SENS_DATA, SAMPLE, DONE, AVG_SD, MODE_SEL,
        output SENS_READY, TN, MODE, RESULT, RESULT_MODE, RESULT_VALID,
               UNDERRUN, OVERFLOW, UNDERRUN_CNT
    );
endinterface

// File: rtl/noaa_sample_feeder.sv
// noaa_sample_feeder
//   Front end for the NOAA averaging/std-dev engine. Buffers 12-bit sensor
//   words in a FIFO, releases one word on TN per engine SAMPLE once the FIFO
//   has been primed, and tags each engine result with the MODE that was in
//   force when its sample was taken.
//   Ports:
//     CLK   - clock, rising edge
//     RESET - synchronous, active-high
//     bus   - noaa_sample_feeder_if.slave (sensor, engine and host signals)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   PRIME | filling FIFO; TN = IDLE_TN, SAMPLE ignored
//   RUN   | each SAMPLE pops one word (or records an underrun) and a tag
module noaa_sample_feeder #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PRIME_CNT = 4,
    parameter int unsigned TAG_DEPTH = 4,
    parameter logic [11:0] IDLE_TN   = 12'h400
) (
    input  logic                 CLK,
    input  logic                 RESET,
    noaa_sample_feeder_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TAG_DEPTH);
    localparam int unsigned TCW = TW + 1;

    typedef enum logic {ST_PRIME, ST_RUN} state_t;

    state_t state_q, state_d;
    logic   in_run;

    logic [11:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic           tag_mem_q [TAG_DEPTH];
    logic [TW-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [TCW-1:0] tag_cnt_q, tag_cnt_d;

    logic [11:0] tn_q, tn_d;
    logic        mode_q, mode_d;
    logic [11:0] result_q, result_d;
    logic        result_mode_q, result_mode_d;
    logic        result_valid_q, result_valid_d;
    logic        underrun_q, underrun_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  und_cnt_q, und_cnt_d;

    logic fifo_full, fifo_empty, push, pop, sample_run;
    logic tag_full, tag_empty, tag_pop, tag_push, tag_drop;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = bus.SENS_VALID && !fifo_full;
    assign sample_run = in_run && bus.SAMPLE;
    assign pop        = sample_run && !fifo_empty;

    assign tag_full  = (tag_cnt_q == TCW'(TAG_DEPTH));
    assign tag_empty = (tag_cnt_q == '0);
    assign tag_pop   = bus.DONE && !tag_empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign tag_push  = sample_run && (!tag_full || tag_pop);
    assign tag_drop  = sample_run && tag_full && !tag_pop;

    // ---- FSM ----
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_PRIME;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_PRIME && count_d >= CW'(PRIME_CNT)) state_d = ST_RUN;
    end

    always_comb begin
        in_run = (state_q == ST_RUN);
    end

    // ---- storage arrays (contents need no reset; pointers define validity) ----
    always_ff @(posedge CLK) begin
        if (push)     mem_q[wr_ptr_q]    <= bus.SENS_DATA;
        if (tag_push) tag_mem_q[tag_wr_q] <= bus.MODE_SEL;
    end

    // ---- next-state datapath ----
    always_comb begin
        wr_ptr_d       = wr_ptr_q + AW'(push);
        rd_ptr_d       = rd_ptr_q + AW'(pop);
        count_d        = count_q + CW'(push) - CW'(pop);
        tag_wr_d       = tag_wr_q + TW'(tag_push);
        tag_rd_d       = tag_rd_q + TW'(tag_pop);
        tag_cnt_d      = tag_cnt_q + TCW'(tag_push) - TCW'(tag_pop);
        tn_d           = tn_q;
        mode_d         = mode_q;
        result_d       = result_q;
        result_mode_d  = result_mode_q;
        result_valid_d = bus.DONE;
        underrun_d     = underrun_q;
        overflow_d     = overflow_q || tag_drop;
        und_cnt_d      = und_cnt_q;

        if (sample_run) begin
            mode_d = bus.MODE_SEL;
            if (!fifo_empty) begin
                tn_d = mem_q[rd_ptr_q];
            end else begin
                underrun_d = 1'b1;
                if (und_cnt_q != 8'hFF) und_cnt_d = und_cnt_q + 8'd1;
            end
        end

        if (bus.DONE) begin
            result_d = bus.AVG_SD;
            if (!tag_empty) begin
                result_mode_d = tag_mem_q[tag_rd_q];
            end else begin
                // Orphan result: best guess is the mode currently driven.
                result_mode_d = mode_q;
                overflow_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            tag_wr_q       <= '0;
            tag_rd_q       <= '0;
            tag_cnt_q      <= '0;
            tn_q           <= IDLE_TN;
            mode_q         <= 1'b0;
            result_q       <= '0;
            result_mode_q  <= 1'b0;
            result_valid_q <= 1'b0;
            underrun_q     <= 1'b0;
            overflow_q     <= 1'b0;
            und_cnt_q      <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            tag_wr_q       <= tag_wr_d;
            tag_rd_q       <= tag_rd_d;
            tag_cnt_q      <= tag_cnt_d;
            tn_q           <= tn_d;
            mode_q         <= mode_d;
            result_q       <= result_d;
            result_mode_q  <= result_mode_d;
            result_valid_q <= result_valid_d;
            underrun_q     <= underrun_d;
            overflow_q     <= overflow_d;
            und_cnt_q      <= und_cnt_d;
        end
    end

    assign bus.SENS_READY   = !fifo_full;
    assign bus.TN           = tn_q;
    assign bus.MODE         = mode_q;
    assign bus.RESULT       = result_q;
    assign bus.RESULT_MODE  = result_mode_q;
    assign bus.RESULT_VALID = result_valid_q;
    assign bus.UNDERRUN     = underrun_q;
    assign bus.OVERFLOW     = overflow_q;
    assign bus.UNDERRUN_CNT = und_cnt_q;
endmodule

// File: doc/noaa_sample_feeder.md
Name: noaa_sample_feeder

Overview:
- Front-end companion to the NOAA averaging/std-dev engine.
- Sensor side: accepts 12-bit temperature words over a valid/ready handshake and buffers them in a FIFO.
- Engine side: presents one word on TN for every SAMPLE pulse from the engine, and drives MODE.
- Result side: collects each AVG_SD on DONE, tags it with the MODE in force at its sample, and reports it to the host with sticky error flags.

Parameters:
- DEPTH, 8, FIFO entries (power of two, 4..16).
- PRIME_CNT, 4, entries required in the FIFO before the first word is released (1..DEPTH).
- TAG_DEPTH, 4, depth of the mode-tag queue (power of two).
- IDLE_TN, 12'h400, value driven on TN before the first release (32 degF code).

Ports:
- CLK  in  1  clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- SENS_VALID  in  1  sensor word valid.
- SENS_DATA  in  12  sensor temperature word.
- SENS_READY  out  1  feeder can accept a word.
- SAMPLE  in  1  engine requests/consumes a sample this cycle.
- TN  out  12  temperature word to the engine.
- MODE  out  1  mode to the engine: 0 = average, 1 = std-dev.
- DONE  in  1  engine result valid.
- AVG_SD  in  12  engine result.
- MODE_SEL  in  1  host mode request.
- RESULT  out  12  last captured result.
- RESULT_MODE  out  1  mode tag of RESULT.
- RESULT_VALID  out  1  one-cycle strobe when RESULT updates.
- UNDERRUN  out  1  sticky: SAMPLE arrived with the FIFO empty while in RUN.
- OVERFLOW  out  1  sticky: tag queue full on push, or DONE arrived with the tag queue empty.
- UNDERRUN_CNT  out  8  saturating count of underrun samples.

Behaviour:
- Reset values:
  - TN=IDLE_TN, MODE=0, RESULT=0, RESULT_MODE=0, RESULT_VALID=0, UNDERRUN=0, OVERFLOW=0, UNDERRUN_CNT=0.
  - FIFO and tag queue empty; state=PRIME.
  - SENS_READY=1 from the first cycle after reset is released.
- Reset in mid-operation discards all buffered data and tags immediately.
- Sensor push:
  - SENS_READY = !fifo_full (combinational from the count).
  - Push occurs when SENS_VALID && SENS_READY.
  - No bypass path: a word pushed in cycle t is poppable no earlier than t+1.
- State PRIME:
  - TN holds IDLE_TN; SAMPLE is ignored (no pop, no tag, no underrun).
  - Go to RUN on the edge where the registered count reaches PRIME_CNT.
- State RUN, on each SAMPLE=1 cycle:
  - If the FIFO is non-empty: pop the head; TN <= head (visible the next cycle).
  - If the FIFO is empty: TN holds its last value; UNDERRUN <= 1; UNDERRUN_CNT increments, saturating at 255.
  - Either way: MODE <= MODE_SEL, and MODE_SEL is pushed to the tag queue.
  - MODE changes only on SAMPLE cycles.
- Simultaneous push and pop:
  - Non-empty FIFO: both occur and the count is unchanged.
  - Full FIFO: READY is low, so only the pop occurs.
  - Empty FIFO: it is an underrun, and the pushed word lands.
- FIFO pointers are log2(DEPTH) bits wide and wrap naturally. The count is log2(DEPTH)+1 bits.
- Result capture, on DONE=1:
  - RESULT <= AVG_SD.
  - RESULT_MODE <= tag-queue head, which is then popped.
  - RESULT_VALID=1 for exactly that following cycle.
- Tag-queue error cases:
  - DONE with the tag queue empty: capture anyway with RESULT_MODE=MODE, and set OVERFLOW.
  - Push to a full tag queue: drop the new tag and set OVERFLOW.
  - Simultaneous tag push and pop are both honoured.
- The state machine never returns to PRIME except through RESET.
- Sticky flags clear only on RESET.

Test Plan:
- Reset, push 3 words (PRIME_CNT=4), hold SAMPLE=1 -> TN stays 12'h400, no underrun. Push a 4th word -> RUN; TN presents words 1..4 in order on consecutive cycles.
- Push 8 words with SENS_VALID held high and no SAMPLE -> SENS_READY drops after the 8th accept. A 9th word is not accepted until the first pop, then READY=1 for one push.
- In RUN with the FIFO empty, 3 SAMPLE cycles -> TN repeats its last value (e.g. 12'h4A0), UNDERRUN=1, UNDERRUN_CNT=3. Then push 12'h510 and SAMPLE -> TN=12'h510.
- MODE_SEL=1 at sample A and 0 at sample B; DONE pulses later with AVG_SD=12'h012 then 12'h440 -> RESULT_MODE=1 then 0, and RESULT_VALID is a one-cycle strobe each time.
- DONE with no outstanding tag -> OVERFLOW=1 and RESULT is updated. Then assert RESET mid-stream -> all outputs return to reset values and state=PRIME.
- Empty FIFO in RUN, push and SAMPLE in the same cycle -> underrun counted; the pushed word appears on TN at the next SAMPLE.
